note_sequencer: RTL and testbench
=================================

// Module: note_sequencer
// PURPOSE
// Autonomous melody player feeding one oscillator's control fields (freq, env reset, enable).
// Reads (pitch, length) steps from a writable step RAM, converts pitch to fixed-point frequency
// via an internal equal-tempered note ROM (C2..C6), and times notes in sample ticks.
// Sits between the control unit / test harness and the oscillator bank, on the system clock.
// PARAMETERS
// DEPTH        64     step RAM entries; address width AW = $clog2(DEPTH)
// FREQ_WIDTH   32     width of freq output, `FIXED_POINT fractional bits
// LEN_WIDTH    4      step length field width, in units
// UNIT_WIDTH   20     width of unit_samples (samples per length unit)
// PORTS
// clk           in   1           system clock
// rst           in   1           asynchronous reset, active high
// sample_tick   in   1           1-cycle strobe per audio sample (48 kHz rate)
// unit_samples  in   UNIT_WIDTH  samples per length unit (e.g. 12413 = 8th @116 bpm); 0 treated as 1
// seq_length    in   AW+1        number of valid steps, 0..DEPTH
// loop_en       in   1           1: wrap to step 0 after last step
// start         in   1           1-cycle pulse: (re)start from step 0
// stop          in   1           1-cycle pulse: halt, gate off
// wr_en         in   1           step RAM write strobe
// wr_addr       in   AW          step RAM write address
// wr_pitch      in   6           note index 0..48 (C2=0, C6=48); 49..63 = rest
// wr_len        in   LEN_WIDTH   step length in units; 0 treated as 1
// freq          out  FREQ_WIDTH  oscillator frequency
// env_reset     out  1           envelope restart request
// gate          out  1           oscillator enable
// playing       out  1           high while not IDLE
// step_idx      out  AW          current step index
// done          out  1           1-cycle pulse when a non-looping sequence ends
// BEHAVIOUR
// - Reset (async, any state): state=IDLE, freq=0, env_reset=0, gate=0, playing=0, step_idx=0,
//   done=0, counter=0. Step RAM contents are not reset.
// - FSM: IDLE -> FETCH -> APPLY -> PLAY -> (FETCH | IDLE).
//   IDLE: outputs hold; gate=0. start with seq_length!=0 -> FETCH, step_idx=0; else ignored.
//   FETCH (1 cycle): synchronous RAM read at step_idx.
//   APPLY (1 cycle): freq <= rom[pitch] (0 for rest); gate <= (pitch<=48);
//     target <= max(len,1)*max(unit_samples,1) (LEN_WIDTH+UNIT_WIDTH bits, no overflow);
//     counter <= 0; env_reset <= 1 only if not rest.
//   PLAY: counter += 1 on each sample_tick. On the tick where counter==target-1:
//     step_idx==seq_length-1: loop_en ? (step_idx=0, FETCH) : (IDLE, gate=0, done=1 one cycle);
//     else step_idx+1, FETCH.
// - Step latency: start pulse -> freq/gate/env_reset valid 2 cycles later (after APPLY).
// - env_reset: set in APPLY, held until the cycle after the next sample_tick, then cleared,
//   guaranteeing the sample_clk domain sees at least one high sample.
// - stop: from any state -> IDLE next cycle, gate=0, env_reset=0, done not pulsed; freq held.
// - stop and start same cycle: stop wins.
// - start while FETCH/APPLY/PLAY: restart at step 0 (-> FETCH), counter cleared.
// - seq_length changed below step_idx+1 while playing: end-of-sequence test uses >=, so the
//   next step boundary wraps/ends immediately.
// - wr_en any time; writes complete in one cycle; a write to the step being played affects
//   only later fetches. Write and FETCH same address same cycle: read returns old data.
// - Note ROM: values from the codebase's standard C2..C6 table, `REAL_TO_FIXED_POINT format.
// TESTING
// - Reset: assert rst mid-PLAY -> all outputs 0 immediately, playing=0, RAM intact.
// - Single step: pitch 33 (A4), len 2, unit 10, seq_length 1, no loop, start -> freq=
//   REAL_TO_FIXED_POINT(440.0), gate=1 after 2 cycles; done after exactly 20 ticks; gate=0.
// - Loop: 3 steps pitches 24,28,31 len 1, unit 4, loop_en=1 -> step_idx 0,1,2,0,... every 4
//   ticks; env_reset high for each step and spans one sample_tick.
// - Rest: pitch 63 -> freq=0, gate=0, env_reset not asserted, duration still honoured.
// - Boundaries: len 0 and unit 0 -> step lasts 1 tick; start with seq_length 0 -> stays IDLE.
// - Control races: start+stop same cycle -> IDLE; start mid-PLAY -> step 0 refetched, counter 0.

Source files
------------

// File: rtl/note_sequencer.sv
// Autonomous melody player: steps (pitch, length) from a step RAM and
// drives one oscillator's freq / env_reset / gate fields.
`ifndef FIXED_POINT
`define FIXED_POINT 16
`endif
`ifndef REAL_TO_FIXED_POINT
`define REAL_TO_FIXED_POINT(x) ($rtoi((x) * (1 << `FIXED_POINT)))
`endif

module note_sequencer #(
    parameter int DEPTH      = 64,
    parameter int FREQ_WIDTH = 32,
    parameter int LEN_WIDTH  = 4,
    parameter int UNIT_WIDTH = 20,
    localparam int AW        = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sample_tick,
    input  logic [UNIT_WIDTH-1:0] unit_samples,
    input  logic [AW:0]           seq_length,
    input  logic                  loop_en,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  wr_en,
    input  logic [AW-1:0]         wr_addr,
    input  logic [5:0]            wr_pitch,
    input  logic [LEN_WIDTH-1:0]  wr_len,
    output logic [FREQ_WIDTH-1:0] freq,
    output logic                  env_reset,
    output logic                  gate,
    output logic                  playing,
    output logic [AW-1:0]         step_idx,
    output logic                  done
);

    localparam int TW = LEN_WIDTH + UNIT_WIDTH;
    localparam int SW = 6 + LEN_WIDTH;

    // Equal-tempered C2..C6; indices 49..63 are rests
    localparam logic [FREQ_WIDTH-1:0] NOTE_ROM [64] = '{
        `REAL_TO_FIXED_POINT(65.406391),  `REAL_TO_FIXED_POINT(69.295658),
        `REAL_TO_FIXED_POINT(73.416192),  `REAL_TO_FIXED_POINT(77.781746),
        `REAL_TO_FIXED_POINT(82.406889),  `REAL_TO_FIXED_POINT(87.307058),
        `REAL_TO_FIXED_POINT(92.498606),  `REAL_TO_FIXED_POINT(97.998859),
        `REAL_TO_FIXED_POINT(103.826174), `REAL_TO_FIXED_POINT(110.0),
        `REAL_TO_FIXED_POINT(116.540940), `REAL_TO_FIXED_POINT(123.470825),
        `REAL_TO_FIXED_POINT(130.812783), `REAL_TO_FIXED_POINT(138.591315),
        `REAL_TO_FIXED_POINT(146.832384), `REAL_TO_FIXED_POINT(155.563492),
        `REAL_TO_FIXED_POINT(164.813778), `REAL_TO_FIXED_POINT(174.614116),
        `REAL_TO_FIXED_POINT(184.997211), `REAL_TO_FIXED_POINT(195.997718),
        `REAL_TO_FIXED_POINT(207.652349), `REAL_TO_FIXED_POINT(220.0),
        `REAL_TO_FIXED_POINT(233.081881), `REAL_TO_FIXED_POINT(246.941651),
        `REAL_TO_FIXED_POINT(261.625565), `REAL_TO_FIXED_POINT(277.182631),
        `REAL_TO_FIXED_POINT(293.664768), `REAL_TO_FIXED_POINT(311.126984),
        `REAL_TO_FIXED_POINT(329.627557), `REAL_TO_FIXED_POINT(349.228231),
        `REAL_TO_FIXED_POINT(369.994423), `REAL_TO_FIXED_POINT(391.995436),
        `REAL_TO_FIXED_POINT(415.304698), `REAL_TO_FIXED_POINT(440.0),
        `REAL_TO_FIXED_POINT(466.163762), `REAL_TO_FIXED_POINT(493.883301),
        `REAL_TO_FIXED_POINT(523.251131), `REAL_TO_FIXED_POINT(554.365262),
        `REAL_TO_FIXED_POINT(587.329536), `REAL_TO_FIXED_POINT(622.253967),
        `REAL_TO_FIXED_POINT(659.255114), `REAL_TO_FIXED_POINT(698.456463),
        `REAL_TO_FIXED_POINT(739.988845), `REAL_TO_FIXED_POINT(783.990872),
        `REAL_TO_FIXED_POINT(830.609395), `REAL_TO_FIXED_POINT(880.0),
        `REAL_TO_FIXED_POINT(932.327523), `REAL_TO_FIXED_POINT(987.766603),
        `REAL_TO_FIXED_POINT(1046.502261),
        '0, '0, '0, '0, '0, '0, '0, '0,
        '0, '0, '0, '0, '0, '0, '0
    };

    typedef enum logic [1:0] {IDLE, FETCH, APPLY, PLAY} state_t;

    state_t                 state;
    logic [SW-1:0]          mem [DEPTH];
    logic [SW-1:0]          rd_data;
    logic [TW-1:0]          counter;
    logic [TW-1:0]          target;

    logic [5:0]             rd_pitch;
    logic [LEN_WIDTH-1:0]   rd_len;
    logic [LEN_WIDTH-1:0]   len_eff;
    logic [UNIT_WIDTH-1:0]  unit_eff;
    logic                   rd_rest;
    logic                   last_step;
    logic                   step_end;

    assign rd_pitch  = rd_data[SW-1:LEN_WIDTH];
    assign rd_len    = rd_data[LEN_WIDTH-1:0];
    assign rd_rest   = (rd_pitch > 6'd48);
    assign len_eff   = (rd_len == '0) ? LEN_WIDTH'(1) : rd_len;
    assign unit_eff  = (unit_samples == '0) ? UNIT_WIDTH'(1) : unit_samples;
    // >= so a shrunk seq_length ends the sequence at the next boundary
    assign last_step = ({1'b0, step_idx} + (AW+1)'(1)) >= seq_length;
    assign step_end  = sample_tick && (counter == target - TW'(1));
    assign playing   = (state != IDLE);

    // Step RAM: read-before-write, so a same-cycle write returns old data
    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_addr] <= {wr_pitch, wr_len};
        if (state == FETCH)
            rd_data <= mem[step_idx];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            freq      <= '0;
            env_reset <= 1'b0;
            gate      <= 1'b0;
            step_idx  <= '0;
            done      <= 1'b0;
            counter   <= '0;
            target    <= '0;
        end else begin
            done <= 1'b0;
            // Hold env_reset through one full sample_tick
            if (env_reset && sample_tick)
                env_reset <= 1'b0;

            if (stop) begin
                state     <= IDLE;
                gate      <= 1'b0;
                env_reset <= 1'b0;
            end else if (start && (state != IDLE || seq_length != '0)) begin
                state    <= FETCH;
                step_idx <= '0;
                counter  <= '0;
            end else begin
                unique case (state)
                    IDLE: begin
                        gate <= 1'b0;
                    end
                    FETCH: begin
                        state <= APPLY;
                    end
                    APPLY: begin
                        freq    <= NOTE_ROM[rd_pitch];
                        gate    <= !rd_rest;
                        target  <= TW'(len_eff) * TW'(unit_eff);
                        counter <= '0;
                        if (!rd_rest)
                            env_reset <= 1'b1;
                        state <= PLAY;
                    end
                    PLAY: begin
                        if (sample_tick)
                            counter <= counter + TW'(1);
                        if (step_end) begin
                            if (!last_step) begin
                                step_idx <= step_idx + AW'(1);
                                state    <= FETCH;
                            end else if (loop_en) begin
                                step_idx <= '0;
                                state    <= FETCH;
                            end else begin
                                state <= IDLE;
                                gate  <= 1'b0;
                                done  <= 1'b1;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_note_sequencer.sv
// Directed bench for note_sequencer: single step, loop, rest,
// length/unit boundaries, control races and async reset.
`timescale 1ns/1ps

module tb_note_sequencer;

  localparam int AW = 6;

  localparam logic [31:0] F_A2 = 32'd7208960;
  localparam logic [31:0] F_A3 = 32'd14417920;
  localparam logic [31:0] F_A4 = 32'd28835840;
  localparam logic [31:0] F_A5 = 32'd57671680;

  logic        clk = 1'b0;
  logic        rst;
  logic        sample_tick;
  logic [19:0] unit_samples;
  logic [AW:0] seq_length;
  logic        loop_en;
  logic        start;
  logic        stop;
  logic        wr_en;
  logic [AW-1:0] wr_addr;
  logic [5:0]  wr_pitch;
  logic [3:0]  wr_len;
  logic [31:0] freq;
  logic        env_reset;
  logic        gate;
  logic        playing;
  logic [AW-1:0] step_idx;
  logic        done;

  int checks   = 0;
  int failures = 0;

  note_sequencer dut (
    .clk          (clk),
    .rst          (rst),
    .sample_tick  (sample_tick),
    .unit_samples (unit_samples),
    .seq_length   (seq_length),
    .loop_en      (loop_en),
    .start        (start),
    .stop         (stop),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_pitch     (wr_pitch),
    .wr_len       (wr_len),
    .freq         (freq),
    .env_reset    (env_reset),
    .gate         (gate),
    .playing      (playing),
    .step_idx     (step_idx),
    .done         (done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic fail(input string tag, input longint o,
                      input longint e);
    failures++;
    $error("FAIL %s observed=%0d expected=%0d", tag, o, e);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    sample_tick = 1'b1;
    cyc();
    sample_tick = 1'b0;
    cyc();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++)
      tick();
  endtask

  task automatic wr(input int a, input int p, input int l);
    wr_en    = 1'b1;
    wr_addr  = AW'(a);
    wr_pitch = 6'(p);
    wr_len   = 4'(l);
    cyc();
    wr_en = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    sample_tick = 0; unit_samples = 0; seq_length = 0;
    loop_en = 0; start = 0; stop = 0;
    wr_en = 0; wr_addr = 0; wr_pitch = 0; wr_len = 0;
    cyc(); cyc();
    checks++;
    if (freq !== 32'd0) fail("rst_freq", freq, 0);
    checks++;
    if (gate !== 1'b0) fail("rst_gate", gate, 0);
    checks++;
    if (env_reset !== 1'b0) fail("rst_env", env_reset, 0);
    checks++;
    if (playing !== 1'b0) fail("rst_play", playing, 0);
    checks++;
    if (step_idx !== 6'd0) fail("rst_idx", step_idx, 0);
    checks++;
    if (done !== 1'b0) fail("rst_done", done, 0);
    rst = 1'b0;
    cyc();

    wr(0, 33, 2);
    unit_samples = 20'd10; seq_length = 7'd1; loop_en = 0;
    pulse_start();
    checks++;
    if (playing !== 1'b1) fail("ss_fetch_play", playing, 1);
    checks++;
    if (gate !== 1'b0) fail("ss_fetch_gate", gate, 0);
    cyc(); cyc();
    checks++;
    if (freq !== F_A4) fail("ss_freq", freq, F_A4);
    checks++;
    if (gate !== 1'b1) fail("ss_gate", gate, 1);
    checks++;
    if (env_reset !== 1'b1) fail("ss_env_pre", env_reset, 1);
    sample_tick = 1'b1;
    cyc();
    sample_tick = 1'b0;
    checks++;
    if (env_reset !== 1'b0) fail("ss_env_post", env_reset, 0);
    cyc();
    ticks(18);
    checks++;
    if (playing !== 1'b1) fail("ss_t19_play", playing, 1);
    checks++;
    if (gate !== 1'b1) fail("ss_t19_gate", gate, 1);
    checks++;
    if (done !== 1'b0) fail("ss_t19_done", done, 0);
    sample_tick = 1'b1;
    cyc();
    sample_tick = 1'b0;
    checks++;
    if (done !== 1'b1) fail("ss_done", done, 1);
    checks++;
    if (gate !== 1'b0) fail("ss_gate_off", gate, 0);
    checks++;
    if (playing !== 1'b0) fail("ss_idle", playing, 0);
    cyc();
    checks++;
    if (done !== 1'b0) fail("ss_done_pulse", done, 0);
    checks++;
    if (freq !== F_A4) fail("ss_freq_hold", freq, F_A4);

    wr(0, 24, 1); wr(1, 28, 1); wr(2, 31, 1);
    unit_samples = 20'd4; seq_length = 7'd3; loop_en = 1'b1;
    pulse_start();
    cyc(); cyc();
    checks++;
    if (step_idx !== 6'd0) fail("lp_idx0", step_idx, 0);
    checks++;
    if (env_reset !== 1'b1) fail("lp_env0", env_reset, 1);
    for (int s = 1; s <= 4; s++) begin
      tick();
      checks++;
      if (env_reset !== 1'b0) fail("lp_env_clr", env_reset, 0);
      ticks(3);
      cyc();
      checks++;
      if (step_idx !== 6'(s % 3))
        fail("lp_idx", step_idx, s % 3);
      checks++;
      if (env_reset !== 1'b1) fail("lp_env", env_reset, 1);
      checks++;
      if (gate !== 1'b1) fail("lp_gate", gate, 1);
    end
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    checks++;
    if (playing !== 1'b0) fail("stop_play", playing, 0);
    checks++;
    if (gate !== 1'b0) fail("stop_gate", gate, 0);
    checks++;
    if (env_reset !== 1'b0) fail("stop_env", env_reset, 0);
    checks++;
    if (done !== 1'b0) fail("stop_done", done, 0);

    wr(0, 63, 3);
    unit_samples = 20'd2; seq_length = 7'd1; loop_en = 1'b0;
    pulse_start();
    cyc(); cyc();
    checks++;
    if (freq !== 32'd0) fail("rest_freq", freq, 0);
    checks++;
    if (gate !== 1'b0) fail("rest_gate", gate, 0);
    checks++;
    if (env_reset !== 1'b0) fail("rest_env", env_reset, 0);
    ticks(5);
    checks++;
    if (playing !== 1'b1) fail("rest_t5_play", playing, 1);
    sample_tick = 1'b1;
    cyc();
    sample_tick = 1'b0;
    checks++;
    if (done !== 1'b1) fail("rest_done", done, 1);
    cyc();

    wr(0, 45, 0);
    unit_samples = 20'd0;
    pulse_start();
    cyc(); cyc();
    checks++;
    if (freq !== F_A5) fail("b0_freq", freq, F_A5);
    checks++;
    if (gate !== 1'b1) fail("b0_gate", gate, 1);
    sample_tick = 1'b1;
    cyc();
    sample_tick = 1'b0;
    checks++;
    if (done !== 1'b1) fail("b0_done", done, 1);
    cyc();

    seq_length = 7'd0;
    pulse_start();
    checks++;
    if (playing !== 1'b0) fail("len0_idle", playing, 0);
    cyc();
    checks++;
    if (playing !== 1'b0) fail("len0_idle2", playing, 0);
    seq_length = 7'd1;
    start = 1'b1; stop = 1'b1;
    cyc();
    start = 1'b0; stop = 1'b0;
    checks++;
    if (playing !== 1'b0) fail("race_idle", playing, 0);

    wr(0, 21, 2); wr(1, 9, 1);
    unit_samples = 20'd3; seq_length = 7'd2;
    pulse_start();
    cyc(); cyc();
    checks++;
    if (freq !== F_A3) fail("rs_freq0", freq, F_A3);
    ticks(6);
    cyc();
    checks++;
    if (step_idx !== 6'd1) fail("rs_idx1", step_idx, 1);
    checks++;
    if (freq !== F_A2) fail("rs_freq1", freq, F_A2);
    tick();
    pulse_start();
    checks++;
    if (step_idx !== 6'd0) fail("rs_idx_restart", step_idx, 0);
    checks++;
    if (playing !== 1'b1) fail("rs_play", playing, 1);
    cyc(); cyc();
    checks++;
    if (freq !== F_A3) fail("rs_freq_re", freq, F_A3);
    ticks(5);
    checks++;
    if (step_idx !== 6'd0) fail("rs_t5_idx", step_idx, 0);
    tick();
    cyc();
    checks++;
    if (step_idx !== 6'd1) fail("rs_t6_idx", step_idx, 1);

    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (freq !== 32'd0) fail("ar_freq", freq, 0);
    checks++;
    if (gate !== 1'b0) fail("ar_gate", gate, 0);
    checks++;
    if (playing !== 1'b0) fail("ar_play", playing, 0);
    checks++;
    if (step_idx !== 6'd0) fail("ar_idx", step_idx, 0);
    checks++;
    if (env_reset !== 1'b0) fail("ar_env", env_reset, 0);
    cyc();
    rst = 1'b0;
    cyc();
    pulse_start();
    cyc(); cyc();
    checks++;
    if (freq !== F_A3) fail("ar_ram_freq", freq, F_A3);
    checks++;
    if (gate !== 1'b1) fail("ar_ram_gate", gate, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
